// File: rtl/cpu_params_pkg.sv
// rtl/cpu_params_pkg.sv - FP register-file sizing and operand-stage bundle types
//
// MAX_FPR  : number of FP registers
// FLEN     : FP register width in bits
// FPR_ASZ  : register address width
// NUM_FS   : source operand slots per instruction (Fs1..Fs3)
// fp_src_t : one source request (enable flag + register address)
// fp_op_t  : registered operand-stage contents handed to execute
package cpu_params_pkg;

    localparam int MAX_FPR = 32;
    localparam int FLEN    = 32;
    localparam int FPR_ASZ = $clog2(MAX_FPR);
    localparam int NUM_FS  = 3;

    typedef struct packed {
        logic               en;
        logic [FPR_ASZ-1:0] addr;
    } fp_src_t;

    typedef struct packed {
        logic [NUM_FS-1:0][FLEN-1:0] fs;
        logic [FPR_ASZ-1:0]          fd_addr;
        logic                        fd_wr;
    } fp_op_t;

endpackage

// File: rtl/fpr_fwd_mux.sv
// rtl/fpr_fwd_mux.sv - one FP source read with same-cycle writeback bypass
//
// fpr      : packed register array from the FP register file
// sb_busy  : scoreboard pending bits
// wb_wr    : writeback strobe
// wb_addr  : writeback destination register
// wb_data  : writeback data
// src      : source request (enable + address)
// rd_data  : forwarded operand, 0 when the source is unused
// raw_hz   : source is pending and not satisfied by this cycle's writeback
module fpr_fwd_mux
    import cpu_params_pkg::*;
(
    input  logic [MAX_FPR*FLEN-1:0] fpr,
    input  logic [MAX_FPR-1:0]      sb_busy,
    input  logic                    wb_wr,
    input  logic [FPR_ASZ-1:0]      wb_addr,
    input  logic [FLEN-1:0]         wb_data,
    input  fp_src_t                 src,
    output logic [FLEN-1:0]         rd_data,
    output logic                    raw_hz
);

    logic [MAX_FPR-1:0][FLEN-1:0] fpr_arr;
    logic                         wb_hit;

    assign fpr_arr = fpr;
    assign wb_hit  = wb_wr && (wb_addr == src.addr);

    // The register file only commits the writeback on the next edge, so the
    // array still holds the stale value this cycle; the bypass covers that.
    always_comb begin
        rd_data = '0;
        if (src.en) begin
            rd_data = wb_hit ? wb_data : fpr_arr[src.addr];
        end
    end

    assign raw_hz = src.en && sb_busy[src.addr] && !wb_hit;

endmodule

// File: rtl/fpr_rd_sb.sv
// rtl/fpr_rd_sb.sv - FP register read stage with pending-write scoreboard
//
// clk_in / reset_in           : clock, asynchronous active-low reset
// fpr                         : packed FP register array
// fpr_Fd_wr/addr/data         : writeback port (array updates next edge)
// req_valid/req_ready         : decode handshake
// req_fs_use/req_fs_addr      : per-slot source enables and addresses
// req_fd_wr/req_fd_addr       : destination of the request
// flush                       : pipeline flush
// op_valid/op_ready           : execute handshake
// op_fs/op_fd_addr/op_fd_wr   : registered operands and destination
// sb_busy                     : scoreboard pending bits
module fpr_rd_sb
    import cpu_params_pkg::*;
(
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [MAX_FPR*FLEN-1:0]   fpr,
    input  logic                      fpr_Fd_wr,
    input  logic [FPR_ASZ-1:0]        fpr_Fd_addr,
    input  logic [FLEN-1:0]           fpr_Fd_data,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [NUM_FS-1:0]         req_fs_use,
    input  logic [NUM_FS*FPR_ASZ-1:0] req_fs_addr,
    input  logic                      req_fd_wr,
    input  logic [FPR_ASZ-1:0]        req_fd_addr,
    input  logic                      flush,
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [NUM_FS*FLEN-1:0]    op_fs,
    output logic [FPR_ASZ-1:0]        op_fd_addr,
    output logic                      op_fd_wr,
    output logic [MAX_FPR-1:0]        sb_busy
);

    logic [MAX_FPR-1:0]          sb_q, sb_d;
    fp_op_t                      op_q, op_d;
    logic                        op_valid_q, op_valid_d;
    logic [NUM_FS-1:0][FLEN-1:0] fwd_data;
    logic [NUM_FS-1:0]           raw_vec;
    logic                        raw_hz, waw_hz, fd_wb_hit, accept;

    for (genvar i = 0; i < NUM_FS; i++) begin : g_src
        fp_src_t src;
        assign src = {req_fs_use[i], req_fs_addr[i*FPR_ASZ +: FPR_ASZ]};

        fpr_fwd_mux u_fwd_mux (
            .fpr     (fpr),
            .sb_busy (sb_q),
            .wb_wr   (fpr_Fd_wr),
            .wb_addr (fpr_Fd_addr),
            .wb_data (fpr_Fd_data),
            .src     (src),
            .rd_data (fwd_data[i]),
            .raw_hz  (raw_vec[i])
        );
    end

    // A pending destination retiring this very cycle frees the slot for a
    // new writer, so the WAW check is masked by the writeback hit.
    assign fd_wb_hit = fpr_Fd_wr && (fpr_Fd_addr == req_fd_addr);
    assign waw_hz    = req_fd_wr && sb_q[req_fd_addr] && !fd_wb_hit;
    assign raw_hz    = |raw_vec;

    // reset_in gates ready so decode sees a stall for the whole reset window.
    assign req_ready = reset_in && !raw_hz && !waw_hz && (!op_valid_q || op_ready) && !flush;
    assign accept    = req_valid && req_ready;

    // Later assignments take priority: flush over set, set over writeback clear.
    always_comb begin
        sb_d = sb_q;
        if (fpr_Fd_wr) begin
            sb_d[fpr_Fd_addr] = 1'b0;
        end
        if (accept && req_fd_wr) begin
            sb_d[req_fd_addr] = 1'b1;
        end
        if (flush) begin
            sb_d = '0;
        end
    end

    always_comb begin
        op_d       = op_q;
        op_valid_d = op_valid_q;
        if (accept) begin
            op_d.fs      = fwd_data;
            op_d.fd_addr = req_fd_addr;
            op_d.fd_wr   = req_fd_wr;
            op_valid_d   = 1'b1;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end
        if (flush) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sb_q       <= '0;
            op_q       <= '0;
            op_valid_q <= 1'b0;
        end else begin
            sb_q       <= sb_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
        end
    end

    // Only elaborated when the address field can name a non-existent register.
    if (MAX_FPR < (1 << FPR_ASZ)) begin : g_addr_chk
        always_ff @(posedge clk_in) begin
            if (reset_in && req_valid && req_fd_wr) begin
                assert (int'(req_fd_addr) < MAX_FPR)
                    else $error("req_fd_addr out of range");
            end
            if (reset_in && fpr_Fd_wr) begin
                assert (int'(fpr_Fd_addr) < MAX_FPR)
                    else $error("fpr_Fd_addr out of range");
            end
        end
    end

    assign sb_busy    = sb_q;
    assign op_valid   = op_valid_q;
    assign op_fs      = op_q.fs;
    assign op_fd_addr = op_q.fd_addr;
    assign op_fd_wr   = op_q.fd_wr;

endmodule

// File: tb/tb_fpr_rd_sb.sv
// tb/tb_fpr_rd_sb.sv - scoreboard bench for fpr_rd_sb against a register-file model
module tb_fpr_rd_sb;
    import cpu_params_pkg::*;

    logic                      clk_in = 1'b0;
    logic                      reset_in = 1'b0;
    logic [MAX_FPR*FLEN-1:0]   fpr;
    logic                      fpr_Fd_wr;
    logic [FPR_ASZ-1:0]        fpr_Fd_addr;
    logic [FLEN-1:0]           fpr_Fd_data;
    logic                      req_valid;
    logic                      req_ready;
    logic [NUM_FS-1:0]         req_fs_use;
    logic [NUM_FS*FPR_ASZ-1:0] req_fs_addr;
    logic                      req_fd_wr;
    logic [FPR_ASZ-1:0]        req_fd_addr;
    logic                      flush;
    logic                      op_valid;
    logic                      op_ready;
    logic [NUM_FS*FLEN-1:0]    op_fs;
    logic [FPR_ASZ-1:0]        op_fd_addr;
    logic                      op_fd_wr;
    logic [MAX_FPR-1:0]        sb_busy;

    typedef struct packed {
        logic [NUM_FS*FLEN-1:0] fs;
        logic [FPR_ASZ-1:0]     fd_addr;
        logic                   fd_wr;
    } exp_t;

    logic [FLEN-1:0] rf [MAX_FPR];
    bit              pend [MAX_FPR];
    exp_t            q [$];
    int              errors = 0;
    int              checks = 0;

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < MAX_FPR; g++) begin : g_rf
        assign fpr[g*FLEN +: FLEN] = rf[g];
    end

    fpr_rd_sb dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .fpr         (fpr),
        .fpr_Fd_wr   (fpr_Fd_wr),
        .fpr_Fd_addr (fpr_Fd_addr),
        .fpr_Fd_data (fpr_Fd_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fs_use  (req_fs_use),
        .req_fs_addr (req_fs_addr),
        .req_fd_wr   (req_fd_wr),
        .req_fd_addr (req_fd_addr),
        .flush       (flush),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_fs       (op_fs),
        .op_fd_addr  (op_fd_addr),
        .op_fd_wr    (op_fd_wr),
        .sb_busy     (sb_busy)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FPR_ASZ-1:0] src(input int i);
        return req_fs_addr[i*FPR_ASZ +: FPR_ASZ];
    endfunction

    function automatic bit wb_hits(input logic [FPR_ASZ-1:0] r);
        return fpr_Fd_wr && (fpr_Fd_addr == r);
    endfunction

    function automatic logic [FLEN-1:0] fwd(input int i);
        if (!req_fs_use[i]) return '0;
        return wb_hits(src(i)) ? fpr_Fd_data : rf[src(i)];
    endfunction

    // Decode may proceed when the execute slot frees up and no source or
    // destination waits on an outstanding writer not retiring this cycle.
    function automatic bit exp_ready();
        bit stall;
        stall = flush || (q.size() != 0 && !op_ready);
        for (int i = 0; i < NUM_FS; i++)
            if (req_fs_use[i] && pend[src(i)] && !wb_hits(src(i))) stall = 1;
        if (req_fd_wr && pend[req_fd_addr] && !wb_hits(req_fd_addr)) stall = 1;
        return !stall;
    endfunction

    task automatic idle();
        req_valid   = 0;
        req_fs_use  = '0;
        req_fs_addr = '0;
        req_fd_wr   = 0;
        req_fd_addr = '0;
        fpr_Fd_wr   = 0;
        fpr_Fd_addr = '0;
        fpr_Fd_data = '0;
        flush       = 0;
        op_ready    = 1;
    endtask

    task automatic set_src(input int i, input bit en, input logic [FPR_ASZ-1:0] a);
        req_fs_use[i] = en;
        req_fs_addr[i*FPR_ASZ +: FPR_ASZ] = a;
    endtask

    task automatic set_wb(input logic [FPR_ASZ-1:0] a, input logic [FLEN-1:0] d);
        fpr_Fd_wr   = 1;
        fpr_Fd_addr = a;
        fpr_Fd_data = d;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic run_cycle(output logic seen);
        bit                 rdy, acc;
        exp_t               e;
        logic [MAX_FPR-1:0] pv;
        #1;
        rdy  = exp_ready();
        seen = req_ready;
        check("req_ready", req_ready, rdy);
        for (int i = 0; i < MAX_FPR; i++) pv[i] = pend[i];
        check("sb_busy", sb_busy, pv);
        acc       = req_valid && rdy;
        e.fs      = {fwd(2), fwd(1), fwd(0)};
        e.fd_addr = req_fd_addr;
        e.fd_wr   = req_fd_wr;
        @(posedge clk_in);
        #1;
        if (flush) begin
            for (int i = 0; i < MAX_FPR; i++) pend[i] = 0;
            q.delete();
        end else begin
            if (fpr_Fd_wr) pend[fpr_Fd_addr] = 0;
            if (acc && req_fd_wr) pend[req_fd_addr] = 1;
        end
        if (fpr_Fd_wr) rf[fpr_Fd_addr] = fpr_Fd_data;
        if (acc) q.push_back(e);
        @(negedge clk_in);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            #2;
            if (reset_in) begin
                check("op_valid", op_valid, q.size() != 0);
                if (op_valid && op_ready && q.size() != 0) begin
                    e = q.pop_front();
                    check("op_fs", op_fs, e.fs);
                    check("op_fd_addr", op_fd_addr, e.fd_addr);
                    check("op_fd_wr", op_fd_wr, e.fd_wr);
                end
            end
        end
    end

    initial begin
        logic            seen;
        logic [95:0]     held;
        for (int i = 0; i < MAX_FPR; i++) rf[i] = $urandom;
        idle();
        req_valid = 1;
        #2;
        check("rst_sb_busy", sb_busy, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_op_fs", op_fs, 0);
        check("rst_op_fd_addr", op_fd_addr, 0);
        check("rst_op_fd_wr", op_fd_wr, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge clk_in);
        reset_in = 1;
        idle();

        // basic read
        rf[3] = 32'h3F80_0000;
        req_valid = 1; set_src(0, 1, 3);
        run_cycle(seen);
        check("t1_ready", seen, 1);
        check("t1_op_valid", op_valid, 1);
        check("t1_fs1", op_fs[31:0], 32'h3F80_0000);

        // RAW stall then release by same-cycle writeback
        idle(); req_valid = 1; req_fd_wr = 1; req_fd_addr = 5;
        run_cycle(seen);
        idle(); req_valid = 1; set_src(1, 1, 5);
        run_cycle(seen);
        check("raw_stall", seen, 0);
        set_wb(5, 32'h4049_0FDB);
        run_cycle(seen);
        check("raw_release", seen, 1);
        check("raw_fs2", op_fs[63:32], 32'h4049_0FDB);
        check("raw_sb5", sb_busy[5], 0);

        // WAW and same-cycle set over clear
        idle(); req_valid = 1; req_fd_wr = 1; req_fd_addr = 7;
        run_cycle(seen);
        run_cycle(seen);
        check("waw_stall", seen, 0);
        set_wb(7, $urandom);
        run_cycle(seen);
        check("waw_accept", seen, 1);
        check("waw_sb7", sb_busy[7], 1);
        idle(); set_wb(7, $urandom);
        run_cycle(seen);

        // backpressure
        idle(); req_valid = 1; set_src(0, 1, 1); op_ready = 0;
        run_cycle(seen);
        held = op_fs;
        set_src(0, 1, 2);
        for (int k = 0; k < 4; k++) begin
            run_cycle(seen);
            check("bp_stall", seen, 0);
            check("bp_hold", op_fs, held);
        end
        op_ready = 1;
        run_cycle(seen);
        check("bp_release", seen, 1);

        // flush with pending writers 4 and 8 and a held operand stage
        idle(); req_valid = 1; req_fd_wr = 1; req_fd_addr = 4;
        run_cycle(seen);
        req_fd_addr = 8;
        run_cycle(seen);
        check("fl_sb_pre", sb_busy, 32'h0000_0110);
        check("fl_valid_pre", op_valid, 1);
        idle(); flush = 1; op_ready = 0; req_valid = 1; set_src(0, 1, 12);
        run_cycle(seen);
        check("fl_ready", seen, 0);
        check("fl_sb_post", sb_busy, 0);
        check("fl_valid_post", op_valid, 0);

        // fused op, all sources on one register with bypass
        idle(); req_valid = 1;
        for (int i = 0; i < NUM_FS; i++) set_src(i, 1, 9);
        set_wb(9, 32'hC000_0000);
        run_cycle(seen);
        check("fma_fs", op_fs, {3{32'hC000_0000}});

        // async reset in the middle of a stall
        idle(); req_valid = 1; req_fd_wr = 1; req_fd_addr = 6;
        run_cycle(seen);
        idle(); req_valid = 1; set_src(0, 1, 6);
        #1;
        check("ar_stall", req_ready, 0);
        #2;
        reset_in = 0;
        #1;
        check("ar_sb", sb_busy, 0);
        check("ar_valid", op_valid, 0);
        check("ar_ready", req_ready, 0);
        for (int i = 0; i < MAX_FPR; i++) pend[i] = 0;
        q.delete();
        @(posedge clk_in);
        #2;
        reset_in = 1;
        @(negedge clk_in);

        // randomized traffic over a narrow register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            idle();
            req_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_FS; i++)
                set_src(i, $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
            req_fd_wr   = $urandom_range(0, 1);
            req_fd_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) set_wb(5'($urandom_range(0, 7)), $urandom);
            op_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            run_cycle(seen);
        end

        idle();
        for (int k = 0; k < 3; k++) run_cycle(seen);
        check("drain_empty", op_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpr_rd_sb.md
Name: fpr_rd_sb

Overview:
- Read side of the RV32F floating-point register file, placed between decode and the FP execute stage.
- Per accepted FP instruction: reads up to three source operands (Fs1/Fs2/Fs3, for fused multiply-add) from the FPR array.
- Forwards same-cycle writeback data over stale array contents.
- Keeps a pending-write scoreboard and stalls decode on RAW/WAW hazards.
- Presents registered operands to execute through a valid/ready handshake.

Parameters:
- MAX_FPR, 32, number of FP registers.
- FLEN, 32, FP register width in bits.
- FPR_ASZ, 5, register address width (clog2 of MAX_FPR).

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- fpr  input  MAX_FPR*FLEN  packed register array from the FP register file.
- fpr_Fd_wr  input  1  writeback strobe; register file updates on the next edge.
- fpr_Fd_addr  input  FPR_ASZ  writeback destination register.
- fpr_Fd_data  input  FLEN  writeback data.
- req_valid  input  1  decode presents an FP instruction.
- req_ready  output  1  instruction accepted this cycle when req_valid is also high.
- req_fs_use  input  3  per-source use flags; bit i selects Fs(i+1).
- req_fs_addr  input  3*FPR_ASZ  source addresses; slot i holds Fs(i+1).
- req_fd_wr  input  1  instruction will write Fd.
- req_fd_addr  input  FPR_ASZ  destination register.
- flush  input  1  pipeline flush.
- op_valid  output  1  operand stage holds valid operands.
- op_ready  input  1  execute consumes the operand stage.
- op_fs  output  3*FLEN  Fs1..Fs3 operand data; unused slots drive 0.
- op_fd_addr  output  FPR_ASZ  destination register, carried with the operands.
- op_fd_wr  output  1  Fd write flag, carried with the operands.
- sb_busy  output  MAX_FPR  scoreboard pending bits, for debug/verification.

Behaviour:
- Reset, asynchronous, reset_in=0:
  - sb_busy = 0, op_valid = 0, op_fs = 0, op_fd_addr = 0, op_fd_wr = 0.
  - req_ready is combinational and is 0 while reset is asserted.
- wb_hit(r) = fpr_Fd_wr & (fpr_Fd_addr == r).
- Per-source read value:
  - wb_hit(addr) → fpr_Fd_data.
  - otherwise → fpr[addr].
- raw_hz: any used source with sb_busy[addr]=1 and !wb_hit(addr).
- waw_hz: req_fd_wr & sb_busy[req_fd_addr] & !wb_hit(req_fd_addr).
- Only one outstanding writer per register is allowed; a 1-bit scoreboard requires this.
- req_ready = !raw_hz & !waw_hz & (!op_valid | op_ready) & !flush. Combinational, no dependence on req_valid.
- Accept = req_valid & req_ready. Latency 1: operands appear on op_fs the cycle after Accept.
- On Accept:
  - Operand stage loads the forwarded values; unused slots load 0.
  - op_fd_addr and op_fd_wr load from the request; op_valid=1.
- Operand stage hold:
  - op_valid & !op_ready → stage holds all contents unchanged.
  - op_ready & !Accept → op_valid=0.
- Scoreboard update per register r, in priority order:
  1. flush → all bits 0.
  2. Accept & req_fd_wr & req_fd_addr==r → 1. Set wins over a same-cycle clear of r.
  3. wb_hit(r) → 0.
  4. otherwise hold.
- Flush: op_valid=0 next cycle and all scoreboard bits cleared. Writebacks arriving after a flush to non-pending registers are legal and ignored by the scoreboard.
- Addresses and registers:
  - Register 0 is a normal register; F0 is not hardwired.
  - Addresses ≥ MAX_FPR must not occur (assertion only).
- Two or more sources may name the same register; each slot gets the same forwarded value.
- Reset mid-operation: the asynchronous clear drops any in-flight operand stage and all pending bits.

Decomposition:
- cpu_params_pkg: MAX_FPR, FLEN, FPR_ASZ.
- cpu_params_pkg also gets fp_src_t (use flag + address) and fp_op_t (3×FLEN operands, fd_addr, fd_wr) for the operand-stage bundle.
- One natural sub-module, fpr_fwd_mux: combinational array read plus writeback bypass for one source. Instantiate three times.
- Scoreboard and operand stage live in the top module.

Test Plan:
- Reset then idle: sb_busy=0, op_valid=0. Request Fs1=3, fpr[3]=0x3F800000, op_ready=1 → req_ready=1; next cycle op_fs[0]=0x3F800000, op_valid=1.
- RAW stall: accept Fd=5 (sb_busy[5]=1), then request Fs2=5 → req_ready=0. Writeback addr 5, data 0x40490FDB the same cycle → accepted; op_fs[1]=0x40490FDB; sb_busy[5]=0.
- WAW plus same-cycle set/clear:
  - Pending Fd=7, new Fd=7 request, no writeback → stall.
  - Writeback to 7 arrives while that request is accepted → sb_busy[7] stays 1.
- Backpressure: op_valid=1, op_ready=0 for 4 cycles → req_ready=0 and op_fs stable. op_ready=1 → the queued request is accepted in the same cycle.
- Flush: sb_busy=0x00000110, op_valid=1, assert flush → next cycle sb_busy=0, op_valid=0; req_ready=0 during the flush cycle.
- Fused op: Fs1=Fs2=Fs3=9 with a same-cycle writeback to 9 of 0xC0000000 → all three op_fs slots = 0xC0000000.
- Async reset asserted mid-stall → sb_busy=0 and op_valid=0 immediately, without waiting for a clock edge.
